// File: rtl/mem_pkg.sv
// Shared definitions for the memory-side line responder: widths, beat geometry,
// FSM state encoding and a helper that selects one word out of a cache line.
package mem_pkg;

    localparam int ADDR_WIDTH = 28;
    localparam int DATA_WIDTH = 32;
    localparam int BLOCK_SIZE = 256;
    localparam int BEATS      = BLOCK_SIZE / DATA_WIDTH;
    localparam int BEAT_WIDTH = $clog2(BEATS);
    localparam int TAG_WIDTH  = ADDR_WIDTH - BEAT_WIDTH;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        READ_BEAT  = 2'b01,
        WRITE_BEAT = 2'b10,
        RESPOND    = 2'b11
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] line_word(
        input logic [BLOCK_SIZE-1:0] line,
        input logic [BEAT_WIDTH-1:0] k
    );
        return line[int'(k) * DATA_WIDTH +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/mem_line_buffer.sv
// One cache line of storage: loaded whole when a request is accepted, patched
// one word at a time as read beats return, and read back one word at a time.
module mem_line_buffer
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BLOCK_SIZE-1:0] load_line,
    input  logic                  word_we,
    input  logic [BEAT_WIDTH-1:0] word_idx,
    input  logic [DATA_WIDTH-1:0] word_data,
    output logic [BLOCK_SIZE-1:0] line_data,
    output logic [DATA_WIDTH-1:0] rd_word
);

    logic [BLOCK_SIZE-1:0] line_q;

    // A full-line load wins over a word patch; the two never coincide in the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_line;
        end else if (word_we) begin
            line_q[int'(word_idx) * DATA_WIDTH +: DATA_WIDTH] <= word_data;
        end
    end

    assign line_data = line_q;
    assign rd_word   = line_word(line_q, word_idx);

endmodule

// File: rtl/mem_block_responder.sv
// Turns one 256-bit line read/write request into eight sequential 32-bit RAM
// beats, then pulses mem_ready with the line for a single cycle.
module mem_block_responder
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BLOCK_SIZE-1:0] mem_wr,
    input  logic                  mem_rw,
    input  logic                  mem_valid,
    output logic [BLOCK_SIZE-1:0] mem_rd,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_req,
    input  logic                  ram_ack,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    state_t                state;
    state_t                state_next;
    logic [BEAT_WIDTH-1:0] beat;
    logic [BEAT_WIDTH-1:0] beat_next;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  capture;
    logic                  word_we;
    logic                  busy;
    logic [BLOCK_SIZE-1:0] line_data;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_addr_bits;

    // The low address bits select a beat, which this block generates itself.
    assign unused_addr_bits = ^mem_addr[BEAT_WIDTH-1:0];

    mem_line_buffer u_line_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture),
        .load_line (mem_wr),
        .word_we   (word_we),
        .word_idx  (beat),
        .word_data (ram_rdata),
        .line_data (line_data),
        .rd_word   (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
            tag   <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            if (capture) begin
                tag <= mem_addr[ADDR_WIDTH-1:BEAT_WIDTH];
            end
        end
    end

    // mem_valid is only looked at on an ack, so a beat in flight always finishes.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        capture    = 1'b0;
        word_we    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    capture    = 1'b1;
                    beat_next  = '0;
                    state_next = mem_rw ? WRITE_BEAT : READ_BEAT;
                end
            end
            READ_BEAT, WRITE_BEAT: begin
                if (ram_ack) begin
                    word_we   = (state == READ_BEAT);
                    beat_next = beat + BEAT_WIDTH'(1);
                    if (!mem_valid) begin
                        state_next = IDLE;
                        beat_next  = '0;
                    end else if (beat == BEAT_WIDTH'(BEATS - 1)) begin
                        state_next = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state == READ_BEAT) || (state == WRITE_BEAT);
    assign ram_req   = busy;
    assign ram_we    = (state == WRITE_BEAT);
    assign ram_addr  = busy ? {tag, beat} : '0;
    assign ram_wdata = busy ? rd_word : '0;
    assign mem_ready = (state == RESPOND);
    assign mem_rd    = mem_ready ? line_data : '0;

endmodule

// File: tb/tb_mem_block_responder.sv
// Randomised bench for mem_block_responder: a transaction-level model predicts
// every RAM beat, the ready cycle and the returned line from the request alone.
module tb_mem_block_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [27:0]  mem_addr;
    logic [255:0] mem_wr;
    logic         mem_rw;
    logic         mem_valid;
    logic [255:0] mem_rd;
    logic         mem_ready;
    logic [27:0]  ram_addr;
    logic [31:0]  ram_wdata;
    logic         ram_we;
    logic         ram_req;
    logic         ram_ack;
    logic [31:0]  ram_rdata;

    typedef struct { logic [27:0] addr; logic we; logic [31:0] wdata; } beat_t;
    typedef struct { int start; int stop; } win_t;
    typedef struct { int at; logic [255:0] line; } rdy_t;

    beat_t beatQ[$];
    win_t  winQ[$];
    rdy_t  rdyQ[$];
    int    waitQ[$];
    logic [31:0] ramMem   [logic [27:0]];
    logic [31:0] modelMem [logic [27:0]];
    int    curWaits[8];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issueCyc = 0;
    int readyCount = 0;
    int lastReadyCyc = -1;
    logic [255:0] lastReadyLine = '0;
    logic [27:0]  lastFirstAddr = '0;
    logic prevReq = 1'b0;
    logic respLoaded = 1'b0;
    int   respCnt = 0;

    mem_block_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_rw    (mem_rw),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_ready (mem_ready),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_req   (ram_req),
        .ram_ack   (ram_ack),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] defaultWord(input logic [27:0] a);
        return {4'h0, a};
    endfunction

    function automatic logic [31:0] modelRead(input logic [27:0] a);
        return modelMem.exists(a) ? modelMem[a] : defaultWord(a);
    endfunction

    function automatic logic [255:0] randomLine();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // RAM model: acks after the scheduled number of wait cycles, data valid with ack.
    initial begin
        ram_ack = 1'b0;
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n || !ram_req) begin
                ram_ack = 1'b0;
                respLoaded = 1'b0;
            end else begin
                if (!respLoaded) begin
                    respCnt = (waitQ.size() > 0) ? waitQ.pop_front() : 0;
                    respLoaded = 1'b1;
                end
                if (respCnt == 0) begin
                    ram_ack = 1'b1;
                    ram_rdata = ramMem.exists(ram_addr) ? ramMem[ram_addr] : defaultWord(ram_addr);
                    if (ram_we) ramMem[ram_addr] = ram_wdata;
                    respLoaded = 1'b0;
                end else begin
                    ram_ack = 1'b0;
                    ram_rdata = $urandom;
                    respCnt--;
                end
            end
        end
    end

    task automatic compareCycle();
        logic expReq;
        logic expRdy;
        while (winQ.size() > 0 && cyc > winQ[0].stop) void'(winQ.pop_front());
        expReq = (winQ.size() > 0) && (cyc >= winQ[0].start);
        checkOutput("ram_req", ram_req, expReq);
        if (ram_req && expReq) begin
            if (beatQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL beat_count actual=extra_beat@%0h required=none", ram_addr);
            end else begin
                checkOutput("ram_addr", ram_addr, beatQ[0].addr);
                checkOutput("ram_we", ram_we, beatQ[0].we);
                if (beatQ[0].we) checkOutput("ram_wdata", ram_wdata, beatQ[0].wdata);
                if (ram_ack) void'(beatQ.pop_front());
            end
        end else if (!ram_req) begin
            checkOutput("ram_we_idle", ram_we, 0);
        end
        while (rdyQ.size() > 0 && cyc > rdyQ[0].at) void'(rdyQ.pop_front());
        expRdy = (rdyQ.size() > 0) && (rdyQ[0].at == cyc);
        checkOutput("mem_ready", mem_ready, expRdy);
        if (expRdy) begin
            checkOutput("mem_rd", mem_rd, rdyQ[0].line);
            void'(rdyQ.pop_front());
        end else begin
            checkOutput("mem_rd_idle", mem_rd, 0);
        end
        if (mem_ready) begin
            readyCount++;
            lastReadyCyc = cyc;
            lastReadyLine = mem_rd;
        end
        if (ram_req && !prevReq) lastFirstAddr = ram_addr;
        prevReq = ram_req;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) compareCycle();
        else prevReq = 1'b0;
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ram_req"}, ram_req, 0);
        checkOutput({tag, "_ram_we"}, ram_we, 0);
        checkOutput({tag, "_ram_addr"}, ram_addr, 0);
        checkOutput({tag, "_ram_wdata"}, ram_wdata, 0);
        checkOutput({tag, "_mem_ready"}, mem_ready, 0);
        checkOutput({tag, "_mem_rd"}, mem_rd, 0);
    endtask

    // Issues one request and predicts its whole timeline from curWaits.
    task automatic applyStimulus(input logic [27:0] addr, input logic rw, input logic [255:0] wr,
                                 input int abortBeat, input int resetBeat, input bit keepValid);
        int c;
        int t;
        int nBeats;
        int dropCyc;
        int stop;
        logic [27:0] a;
        logic [255:0] expLine;
        c = cyc;
        issueCyc = c;
        mem_addr = addr;
        mem_rw = rw;
        mem_wr = wr;
        mem_valid = 1'b1;
        nBeats = 8;
        if (abortBeat >= 0) nBeats = abortBeat + 1;
        if (resetBeat >= 0) nBeats = resetBeat;
        for (int k = 0; k < 8; k++) begin
            a = {addr[27:3], 3'(k)};
            expLine[32*k +: 32] = rw ? wr[32*k +: 32] : modelRead(a);
        end
        t = c + 1;
        dropCyc = -1;
        for (int k = 0; k < nBeats; k++) begin
            if (k == abortBeat) dropCyc = t;
            a = {addr[27:3], 3'(k)};
            beatQ.push_back('{a, rw, wr[32*k +: 32]});
            waitQ.push_back(curWaits[k]);
            t += curWaits[k] + 1;
            if (rw) modelMem[a] = wr[32*k +: 32];
        end
        stop = t - 1;
        winQ.push_back('{c + 1, stop});
        if (abortBeat < 0 && resetBeat < 0) rdyQ.push_back('{stop + 1, expLine});
        if (abortBeat >= 0) begin
            waitUntil(dropCyc);
            mem_valid = 1'b0;
            waitUntil(stop + 1);
        end else if (resetBeat >= 0) begin
            waitUntil(stop + 1);
            rst_n = 1'b0;
            mem_valid = 1'b0;
            beatQ.delete();
            winQ.delete();
            rdyQ.delete();
            waitQ.delete();
            respLoaded = 1'b0;
            #1;
            checkAllZero("midreset");
            waitUntil(cyc + 2);
            rst_n = 1'b1;
        end else begin
            waitUntil(stop + 2);
            if (!keepValid) mem_valid = 1'b0;
        end
    endtask

    task automatic setWaits(input int w);
        for (int k = 0; k < 8; k++) curWaits[k] = w;
    endtask

    task automatic randomWaits();
        for (int k = 0; k < 8; k++) curWaits[k] = $urandom_range(0, 3);
    endtask

    initial begin
        logic [255:0] wr;
        logic [27:0]  line;
        int r0;
        int first;
        bit keep;
        mem_addr = '0;
        mem_wr = '0;
        mem_rw = 1'b0;
        mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait read: RAM returns each word's own address.
        setWaits(0);
        applyStimulus(28'h0001238, 1'b0, randomLine(), -1, -1, 1'b0);
        checkOutput("t1_latency", lastReadyCyc - issueCyc, 9);
        checkOutput("t1_first_addr", lastFirstAddr, 28'h0001238);
        checkOutput("t1_word0", lastReadyLine[31:0], 32'h00001238);
        checkOutput("t1_word7", lastReadyLine[255:224], 32'h0000123F);

        // Write with two wait cycles per beat.
        setWaits(2);
        for (int k = 0; k < 8; k++) wr[32*k +: 32] = 32'hA0 + k;
        applyStimulus(28'h0004565, 1'b1, wr, -1, -1, 1'b0);
        checkOutput("t2_latency", lastReadyCyc - issueCyc, 25);
        checkOutput("t2_line", lastReadyLine, wr);
        checkOutput("t2_ram_word3", ramMem.exists(28'h0004563) ? ramMem[28'h0004563] : 32'h0, 32'hA3);

        // Flush sweep: four lines with mem_valid held throughout.
        setWaits(0);
        r0 = readyCount;
        first = cyc;
        for (int i = 0; i < 4; i++)
            applyStimulus(28'h0008000 + 28'(8 * i), 1'b1, randomLine(), -1, -1, i < 3);
        checkOutput("sweep_ready_count", readyCount - r0, 4);
        checkOutput("sweep_period", lastReadyCyc - first, 39);

        // Abort during beat 3 of a read, then a normal read.
        randomWaits();
        r0 = readyCount;
        applyStimulus(28'h000A000, 1'b0, randomLine(), 3, -1, 1'b0);
        waitUntil(cyc + 2);
        checkOutput("abort_no_ready", readyCount, r0);
        randomWaits();
        applyStimulus(28'h000B004, 1'b0, randomLine(), -1, -1, 1'b0);
        checkOutput("after_abort_first_addr", lastFirstAddr, 28'h000B000);

        // Reset during beat 5 of a write, then read the partially written line.
        setWaits(0);
        line = 28'h000C000;
        wr = randomLine();
        applyStimulus(line, 1'b1, wr, -1, 5, 1'b0);
        @(posedge clk);
        #1;
        randomWaits();
        applyStimulus(line, 1'b0, randomLine(), -1, -1, 1'b0);
        checkOutput("partial_word4", lastReadyLine[159:128], wr[159:128]);
        checkOutput("partial_word5", lastReadyLine[191:160], defaultWord(line + 28'd5));

        // Random traffic over a few lines so reads see earlier writes.
        keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!keep && $urandom_range(0, 1) == 1) waitUntil(cyc + $urandom_range(1, 3));
            randomWaits();
            keep = (i < 39) && ($urandom_range(0, 2) == 0);
            applyStimulus({20'h00010, 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7))},
                          1'($urandom_range(0, 1)), randomLine(), -1, -1, keep);
        end
        waitUntil(cyc + 3);
        checkOutput("model_drained", beatQ.size() + rdyQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_block_responder.md
# mem_block_responder

Memory-side responder for the data-cache line protocol: it accepts 256-bit block read (allocate) and write (write-back/flush) requests from the cache controller and performs each one as eight sequential 32-bit word transfers on a simple word-wide RAM port. It sits between the D-cache controller's `mem_*` interface and the main-memory word port. It supports back-to-back requests, as issued by a flush sweep.

## Interface
- `ADDR_WIDTH`, 28: word address width on both sides.
- `DATA_WIDTH`, 32: RAM word width.
- `BLOCK_SIZE`, 256: line width. BEATS = BLOCK_SIZE/DATA_WIDTH = 8.

Clock and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `mem_addr`  in  28  line word address; bits [2:0] are ignored and treated as 0.
- `mem_wr`  in  256  write line; word k is bits [32k+31:32k].
- `mem_rw`  in  1  1 = write line, 0 = read line.
- `mem_valid`  in  1  request valid; held high by the initiator until `mem_ready`.
- `mem_rd`  out  256  read line; valid only while `mem_ready`=1, otherwise 0.
- `mem_ready`  out  1  one-cycle completion pulse.
- `ram_addr`  out  28  word address {line[27:3], beat}.
- `ram_wdata`  out  32  write word.
- `ram_we`  out  1  1 = write beat.
- `ram_req`  out  1  beat request; held until `ram_ack`.
- `ram_ack`  in  1  beat done; `ram_rdata` is valid in the same cycle; zero-wait is allowed.
- `ram_rdata`  in  32  read word.

## Operation
States: IDLE, READ_BEAT, WRITE_BEAT, RESPOND.

- **IDLE.** When `mem_valid`=1:
  - capture `mem_addr[27:3]`, `mem_rw`, and `mem_wr` into the line buffer;
  - clear beat to 0;
  - go to WRITE_BEAT if `mem_rw`, else READ_BEAT.
- **READ_BEAT / WRITE_BEAT.**
  - Outputs: `ram_req`=1, `ram_addr`={tag_index, beat}, `ram_we`=(state==WRITE_BEAT), `ram_wdata`=buffer word[beat].
  - On `ram_ack` in a read, store `ram_rdata` into buffer word[beat].
  - On `ram_ack` with beat==7, go to RESPOND; otherwise beat++.
- **RESPOND.**
  - `mem_ready`=1 and `mem_rd`=buffer for exactly one cycle.
  - Always go to IDLE next.
  - If `mem_valid` is still high in the following IDLE cycle, that is a new request: the initiator has already advanced `mem_addr`.
- **Abort.** `mem_valid` is sampled on every `ram_ack`. If it is 0:
  - the current beat completes (a RAM handshake is never abandoned);
  - the state returns to IDLE with no `mem_ready`;
  - a partially written line stays partially written, which is acceptable.
- **Address arithmetic.** Beat is a 3-bit counter that wraps 7→0. `ram_addr[2:0]` is always the beat, never `mem_addr[2:0]`.
- **Input changes.** Changes to `mem_wr` or `mem_addr` after capture are ignored until the next IDLE capture.

## Timing
- **Reset values.** Every output is 0: `mem_ready`, `mem_rd`, `ram_req`, `ram_we`, `ram_addr`, `ram_wdata`. The state goes to IDLE and the beat counter to 0.
- **Latency.** Capture happens at edge E0. Beats run during cycles 1..8 with zero-wait ack. `mem_ready` is high in cycle 9. Each RAM wait cycle adds one cycle.
- **Back-to-back.** The minimum request-to-request spacing is one IDLE cycle after RESPOND, giving a 10-cycle line period at zero wait.
- **`ram_req` behaviour.** `ram_req` stays continuously high across beats; there is no deassert gap between beats.
- **Output registering.** All outputs are registered or decoded from the registered state only. There is no combinational path from `mem_*` inputs to `ram_*` outputs.
- **Reset mid-transaction.** Outputs clear immediately. No RESPOND is issued.

## Structure
- **Shared package `mem_pkg`:**
  - state encoding: IDLE=2'b00, READ_BEAT=2'b01, WRITE_BEAT=2'b10, RESPOND=2'b11;
  - BEATS;
  - the beat-index width;
  - a line word-select function for word k.
- **Sub-module `mem_line_buffer`:**
  - 256-bit register;
  - full-line load on capture;
  - single-word write by index on read ack;
  - word read by index.
- The FSM, beat counter and abort logic stay in the top module.

## Test plan
- **Read, zero-wait.** `mem_addr`=28'h0001238, `mem_rw`=0, RAM returns word = {addr}. Required:
  - `ram_addr` sequence 0x0001238..0x000123F;
  - `mem_ready` in cycle 9;
  - `mem_rd` word k = 0x0001238+k.
- **Write with wait states.** `mem_rw`=1, `mem_wr` = 32'hA0..A7 per word, `ram_ack` after 2 wait cycles per beat. Required:
  - 8 writes with `ram_we`=1 and data A0..A7 in order;
  - `mem_ready` at cycle 25;
  - `mem_rd`=0 outside the ready cycle.
- **Flush sweep.** `mem_valid` held high with `mem_addr` advancing by 8 after each `mem_ready`, over 4 lines. Required:
  - 4 distinct 8-beat bursts;
  - exactly one IDLE cycle between RESPOND and the next burst.
- **Abort.** Drop `mem_valid` during beat 3 of a read. Required:
  - beat 3 completes;
  - the state returns to IDLE;
  - no `mem_ready`;
  - the next request starts at beat 0.
- **Reset mid-burst.** Assert `rst_n`=0 during beat 5 of a write. Required:
  - all outputs are 0 asynchronously;
  - after release, a new read completes normally.
